// File: rtl/axi_lite_stim_master_pkg.sv
// Shared FSM state type, AXI constants and the xorshift64 step function
// used by the AXI4-Lite stimulus master and its PRNG sub-block.
package axi_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_RD     = 3'd3,
    ST_WAIT_R = 3'd4,
    ST_DONE   = 3'd5
  } stim_state_e;

  localparam logic [2:0]  AXI_PROT_DATA         = 3'b000;
  localparam logic [3:0]  WSTRB_FULL            = 4'hF;
  localparam logic [63:0] XORSHIFT_DEFAULT_SEED = 64'd88172645463325252;

  function automatic logic [63:0] xorshift64_next(input logic [63:0] s);
    logic [63:0] t;
    t = s ^ (s << 6'd13);
    t = t ^ (t >> 6'd7);
    t = t ^ (t << 6'd17);
    return t;
  endfunction

endpackage

// File: rtl/axi_lite_stim_master_if.sv
// AXI4-Lite bus bundle between the stimulus master and a memory-style responder.
interface axi_lite_stim_master_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );

endinterface

// File: rtl/axi_lite_stim_master_xorshift.sv
// Registered xorshift64 generator; load restarts from seed and may be combined
// with step so the first value after a load is already one step past the seed.
module xorshift64_step
  import axi_stim_pkg::*;
#(
  parameter logic [63:0] SEED = XORSHIFT_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [63:0] seed,
  output logic [63:0] state,
  output logic [63:0] state_nxt
);

  logic [63:0] state_r;
  logic [63:0] base_s;
  logic [63:0] state_nxt_s;

  // Value the register takes at the next edge.
  always_comb begin
    base_s      = state_r;
    state_nxt_s = state_r;
    if (load) begin
      base_s = seed;
    end else begin
      base_s = state_r;
    end
    if (step) begin
      state_nxt_s = xorshift64_next(base_s);
    end else begin
      state_nxt_s = base_s;
    end
  end

  // PRNG state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= SEED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign state     = state_r;
  assign state_nxt = state_nxt_s;

endmodule

// File: rtl/axi_lite_stim_master.sv
// AXI4-Lite initiator: writes pseudo-random words to pseudo-random addresses,
// reads each back and counts mismatches.
module axi_lite_stim_master
  import axi_stim_pkg::*;
#(
  parameter int unsigned NUM_TXN    = 64,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int unsigned ADDR_WORDS = 16,
  parameter logic [63:0] SEED       = XORSHIFT_DEFAULT_SEED
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   err_count,
  output logic [31:0]                   last_err_addr,
  axi_lite_stim_master_if.master        mem_axi
);

  localparam logic [31:0] ADDR_MASK = 32'(ADDR_WORDS - 1);
  localparam logic [15:0] LAST_TXN  = 16'(NUM_TXN - 1);

  function automatic logic [31:0] addr_of(input logic [63:0] s);
    return ADDR_BASE + ((s[63:32] & ADDR_MASK) << 5'd2);
  endfunction

  stim_state_e state_r;
  logic [15:0] txn_r;
  logic        busy_r, done_r, aw_done_r, w_done_r;
  logic        awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
  logic [31:0] addr_r, data_r, last_err_addr_r;
  logic [3:0]  wstrb_r;
  logic [15:0] err_count_r;
  logic [63:0] prng_state_s, prng_nxt_s;
  logic        accept_s, r_hs_s, last_txn_s, prng_load_s, prng_step_s;
  logic        aw_hs_s, w_hs_s, aw_all_s, w_all_s, mismatch_s;

  xorshift64_step #(.SEED(SEED)) u_prng (
    .clk       (clk),
    .reset     (reset),
    .load      (prng_load_s),
    .step      (prng_step_s),
    .seed      (SEED),
    .state     (prng_state_s),
    .state_nxt (prng_nxt_s)
  );

  // Handshake decode and PRNG control; the PRNG advances on the edge that launches a write.
  always_comb begin
    accept_s    = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
    r_hs_s      = (state_r == ST_WAIT_R) && mem_axi.rvalid && rready_r;
    last_txn_s  = (txn_r == LAST_TXN);
    prng_load_s = accept_s;
    prng_step_s = accept_s || (r_hs_s && !last_txn_s);
    aw_hs_s     = awvalid_r && mem_axi.awready;
    w_hs_s      = wvalid_r && mem_axi.wready;
    aw_all_s    = aw_done_r || aw_hs_s;
    w_all_s     = w_done_r || w_hs_s;
    mismatch_s  = (mem_axi.rdata != data_r);
  end

  // Transaction FSM with registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      txn_r           <= 16'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      aw_done_r       <= 1'b0;
      w_done_r        <= 1'b0;
      awvalid_r       <= 1'b0;
      wvalid_r        <= 1'b0;
      bready_r        <= 1'b0;
      arvalid_r       <= 1'b0;
      rready_r        <= 1'b0;
      addr_r          <= 32'd0;
      data_r          <= 32'd0;
      wstrb_r         <= 4'd0;
      err_count_r     <= 16'd0;
      last_err_addr_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            state_r     <= ST_WR;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            err_count_r <= 16'd0;
            txn_r       <= 16'd0;
            awvalid_r   <= 1'b1;
            wvalid_r    <= 1'b1;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            addr_r      <= addr_of(prng_nxt_s);
            data_r      <= prng_nxt_s[31:0];
            wstrb_r     <= WSTRB_FULL;
          end
        end
        ST_WR: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (aw_all_s && w_all_s) begin
            state_r  <= ST_WAIT_B;
            bready_r <= 1'b1;
          end
        end
        ST_WAIT_B: begin
          if (mem_axi.bvalid) begin
            bready_r  <= 1'b0;
            arvalid_r <= 1'b1;
            state_r   <= ST_RD;
          end
        end
        ST_RD: begin
          if (mem_axi.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (r_hs_s) begin
            rready_r <= 1'b0;
            if (mismatch_s) begin
              if (err_count_r != 16'hFFFF) begin
                err_count_r <= err_count_r + 16'd1;
              end
              last_err_addr_r <= addr_of(prng_state_s);
            end
            if (last_txn_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= ST_WR;
              txn_r     <= txn_r + 16'd1;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              addr_r    <= addr_of(prng_nxt_s);
              data_r    <= prng_nxt_s[31:0];
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign err_count        = err_count_r;
  assign last_err_addr    = last_err_addr_r;
  assign mem_axi.awvalid  = awvalid_r;
  assign mem_axi.awaddr   = addr_r;
  assign mem_axi.awprot   = AXI_PROT_DATA;
  assign mem_axi.wvalid   = wvalid_r;
  assign mem_axi.wdata    = data_r;
  assign mem_axi.wstrb    = wstrb_r;
  assign mem_axi.bready   = bready_r;
  assign mem_axi.arvalid  = arvalid_r;
  assign mem_axi.araddr   = addr_r;
  assign mem_axi.arprot   = AXI_PROT_DATA;
  assign mem_axi.rready   = rready_r;

endmodule

// File: doc/axi_lite_stim_master.md
Name: axi_lite_stim_master

Overview:
Synthesizable AXI4-Lite initiator that drives self-checking write/read-back traffic into any AXI4-Lite responder, such as the memory model or an on-chip RAM bridge. Each transaction writes a pseudo-random word to a pseudo-random word address, then reads that address back and compares the result. It exercises responders on hardware/FPGA without a CPU and reports a pass/fail summary.

Parameters:
NUM_TXN, 64, number of write+readback pairs per run (1..65535)
ADDR_BASE, 32'h0000_0000, byte base address of target window (word aligned)
ADDR_WORDS, 16, window size in 32-bit words; power of two, 1..2^16
SEED, 64'd88172645463325252, xorshift64 seed, loaded on reset and on every accepted start

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a run when not busy
busy  out  1  high from the cycle after an accepted start until done is set
done  out  1  set when a run completes; held until next accepted start
err_count  out  16  readback mismatches in the current run, saturating at 16'hFFFF
last_err_addr  out  32  byte address of the most recent mismatch
mem_axi_awvalid/awready/awaddr[32]/awprot[3]  out/in/out/out  AXI4-Lite write address channel
mem_axi_wvalid/wready/wdata[32]/wstrb[4]  out/in/out/out  write data channel
mem_axi_bvalid/bready  in/out  write response channel
mem_axi_arvalid/arready/araddr[32]/arprot[3]  out/in/out/out  read address channel
mem_axi_rvalid/rready/rdata[32]  in/out/in  read data channel

Behaviour:
- Reset: asynchronous, active-high; all outputs 0; state IDLE; PRNG=SEED; counters 0.
- PRNG step: s^=s<<13; s^=s>>7; s^=s<<17 (64-bit, sequential). One step per transaction, taken before its use. Txn k uses the state after k+1 steps from SEED.
- Address: ADDR_BASE + ((s[63:32] & (ADDR_WORDS-1)) << 2). Data: s[31:0]. wstrb=4'hF. awprot=arprot=3'b000.
- FSM states: IDLE, WR, WAIT_B, RD, WAIT_R, DONE.
- IDLE/DONE + start: reseed, step PRNG, clear err_count, txn=0, done=0, busy=1; WR on the next cycle.
- WR: awvalid and wvalid assert in the same cycle. Each channel drops independently on its own handshake (valid&ready at a posedge); flags aw_done/w_done record completion. When both are done, go to WAIT_B. This holds even when both handshakes fall in one cycle.
- WAIT_B: bready=1; on bvalid, go to RD.
- RD: arvalid=1, araddr = the address just written; on arready, go to WAIT_R.
- WAIT_R: rready=1; on rvalid, compare rdata with the written data. On mismatch, err_count++ (saturating) and last_err_addr updates.
  - If txn==NUM_TXN-1: go to DONE (done=1, busy=0).
  - Else: txn++, step PRNG, go to WR.
- AXI rules:
  - Valids never depend combinationally on readys.
  - Once a valid is asserted, it and its addr/data stay stable until handshake.
  - bready and rready are asserted only in their wait states; a responder may present bvalid/rvalid earlier and hold it.
- Minimum per-txn latency with an always-ready zero-wait responder: 4 cycles (WR, WAIT_B, RD, WAIT_R).
- start while busy: ignored, no effect on the run.
- Reset mid-transaction: valids drop immediately (async); a restarted run is identical to a fresh one.
- ADDR_WORDS=1: every txn targets ADDR_BASE.

Decomposition:
- Shared package axi_stim_pkg: FSM state enum; AXI_PROT_DATA=3'b000; WSTRB_FULL=4'hF; XORSHIFT_DEFAULT_SEED.
- One sub-module: xorshift64_step (combinational next-state plus registered state with load/step enables), reusable by other stimulus blocks.

Test Plan:
- Zero-wait RAM responder, NUM_TXN=4, defaults -> done after start+16 cycles (±1), err_count=0, addresses/data match golden xorshift model.
- awready delayed 3 cycles, wready immediate (then reverse) -> wvalid drops after 1 cycle, awvalid held 3 with stable awaddr; exactly one write per txn; WAIT_B entered only after both handshakes.
- Responder corrupts rdata bit0 on txn 2 of 4 -> err_count=1, last_err_addr = txn-2 address, done=1.
- bvalid/rvalid asserted early and held; random arready/rready stalls of 0..7 cycles over 1000 txns -> err_count=0, no protocol violation (valid stable until ready).
- Assert reset while in WAIT_R, release, then pulse start -> all outputs 0 during reset; restarted run reproduces the txn-0 address/data from SEED.
- Pulse start mid-run, then again after done -> first pulse ignored (txn count unchanged); second clears done and err_count and repeats an identical sequence.
